one_bit_demultiplexer: RTL and testbench
========================================

# one_bit_demultiplexer

Registered 1-to-2 demultiplexer with valid/ready handshakes, the steering counterpart of the 2:1 `one_bit_multiplexer`. It accepts one 32-bit word per cycle from a single producer and routes it, by a `control` bit, to either the `up` or the `down` consumer. Each output owns a 2-entry skid buffer, so a stalled consumer never blocks traffic already accepted for the other one. Sits in the core where one result must be forwarded to one of two sinks, e.g. register-file writeback vs CSR/side path.

## Interface
- `WIDTH`, 32, data width of all data ports
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  WIDTH  word from producer
- `control`  in  1  destination select: 0 = up, 1 = down
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  block accepts the word this cycle
- `out_up` / `out_down`  out  WIDTH  head word of each buffer
- `up_valid` / `down_valid`  out  1  buffer non-empty
- `up_ready` / `down_ready`  in  1  consumer takes the head word

## Operation
- Transfer on the input when `in_valid && in_ready` at a rising edge; the word is pushed into the buffer chosen by `control` in that cycle.
- `in_ready` = selected buffer not full. Combinational from `control` and buffer state only; never depends on `in_valid` or the output ready signals.
- Producer rule: `in_data` and `control` stay stable while `in_valid` is high and not yet accepted.
- Each buffer is a 2-entry FIFO with states EMPTY, ONE, TWO:
  - EMPTY: push -> ONE.
  - ONE: push only -> TWO; pop only -> EMPTY; push and pop -> ONE, with the new word at the head.
  - TWO: pop -> ONE; push is impossible because `in_ready` is low for that side.
- Pop when `*_valid && *_ready`. `*_valid` is high exactly in ONE and TWO. The data output shows the oldest word.
- Words stay in order within each output. There is no ordering between the two outputs.
- The unselected buffer is unaffected by input activity and may pop in the same cycle.
- `*_ready` while `*_valid` is low has no effect.
- Reset (asynchronous, any time, including mid-transfer):
  - Both buffers go to EMPTY and all stored words are discarded.
  - `out_up` and `out_down` = 0; `up_valid` and `down_valid` = 0.
  - `in_ready` = 1 from the first cycle after reset.

## Timing
- Latency 1 cycle: a word accepted at edge N shows as `*_valid` = 1 with its data after edge N, visible in cycle N+1.
- Throughput: 1 word/cycle per output with its consumer ready every cycle.
- When the consumer stalls, each output absorbs 2 words before `in_ready` drops for that side.
- When a buffer is full and the consumer pops in the same cycle, `in_ready` is still low in that cycle; the slot becomes available the next cycle.
- All outputs except `in_ready` are driven directly from registers.

## Configuration
- `ONE_BIT_DEMUX_STATS_EN` defined:
  - Adds two 16-bit output counters, `up_count` and `down_count`.
  - Each counts accepted input words routed to its side, wraps 0xFFFF -> 0, and resets to 0.
- Not defined: the ports and the counter logic are absent and behaviour is otherwise identical.

## Structure
- Shared package `core_pkg` holds:
  - `DATA_WIDTH` = 32.
  - The buffer-state enum `buf_state_t` {`BUF_EMPTY`, `BUF_ONE`, `BUF_TWO`}.
  - Select encodings `SEL_UP` = 0 and `SEL_DOWN` = 1.
- Sub-module `demux_skid_buffer`: one 2-entry FIFO with push/pop handshake.
- The top instantiates it twice and adds the select logic for push and `in_ready`.

## Test plan
- Reset, then push 0xDEADBEEF with `control`=0 and `up_ready`=1:
  - `up_valid` high for exactly 1 cycle, the cycle after acceptance, with `out_up` = 0xDEADBEEF.
  - `down_valid` stays 0.
- Hold `down_ready`=0 and push 0x1, 0x2, 0x3 with `control`=1:
  - Third word: `in_ready`=0 and the word is not accepted.
  - Then raise `down_ready`: outputs 0x1, 0x2, then the stalled 0x3 is accepted; order preserved.
- Down side full and stalled, then push 0xA with `control`=0:
  - Accepted immediately; it appears on `out_up` next cycle.
- Back-to-back stream 0x10..0x1F alternating `control` with both readies high:
  - Every cycle accepted.
  - Each side receives its 8 words in order, each 1 cycle after acceptance.
- Assert `rst` while the up side holds 2 words:
  - All valids 0 and data 0 immediately.
  - After release, `in_ready`=1 and no old words appear.
- With `ONE_BIT_DEMUX_STATS_EN` defined, preload `up_count`=0xFFFF and push one up word:
  - `up_count` = 0x0000; `down_count` unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core package: data width, skid-buffer state encoding and
// demux select encodings used by the one_bit_demultiplexer slice.
package core_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    localparam logic SEL_UP   = 1'b0;
    localparam logic SEL_DOWN = 1'b1;

endpackage

// File: rtl/one_bit_demultiplexer_if.sv
// Handshake bundle for the 1-to-2 demultiplexer.
// Ports: producer side (in_data, control, in_valid, in_ready) and two
// consumer sides (out_up/up_valid/up_ready, out_down/down_valid/down_ready).
// With ONE_BIT_DEMUX_STATS_EN defined, up_count/down_count are added.
// Modports: master = producer/consumer environment, slave = the demux.
interface one_bit_demultiplexer_if #(
    parameter int WIDTH = core_pkg::DATA_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             control;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_up;
    logic [WIDTH-1:0] out_down;
    logic             up_valid;
    logic             down_valid;
    logic             up_ready;
    logic             down_ready;
`ifdef ONE_BIT_DEMUX_STATS_EN
    logic [15:0]      up_count;
    logic [15:0]      down_count;
`endif

    modport master (
        output in_data, control, in_valid, up_ready, down_ready,
`ifdef ONE_BIT_DEMUX_STATS_EN
        input  up_count, down_count,
`endif
        input  in_ready, out_up, out_down, up_valid, down_valid
    );

    modport slave (
        input  in_data, control, in_valid, up_ready, down_ready,
`ifdef ONE_BIT_DEMUX_STATS_EN
        output up_count, down_count,
`endif
        output in_ready, out_up, out_down, up_valid, down_valid
    );
endinterface

// File: rtl/demux_skid_buffer.sv
// Two-entry FIFO with push/pop handshake; head word and valid are registered.
// Ports: clk, rst (async high), push/push_data in, pop_ready in,
// full/valid/head out. Caller must not push while full.
module demux_skid_buffer
    import core_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head
);
    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             valid_q, valid_d;
    logic             pop;

    assign pop   = valid_q && pop_ready;
    assign full  = (state_q == BUF_TWO);
    assign valid = valid_q;
    assign head  = head_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    state_d = BUF_ONE;
                    head_d  = push_data;
                end
            end
            BUF_ONE: begin
                if (push && pop) begin
                    // old head leaves, new word becomes the head
                    head_d = push_data;
                end else if (push) begin
                    state_d = BUF_TWO;
                    tail_d  = push_data;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    state_d = BUF_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        valid_d = (state_d != BUF_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/one_bit_demultiplexer.sv
// Registered 1-to-2 demultiplexer: control=0 routes to up, 1 to down.
// Ports: clk, rst (async high), bus (one_bit_demultiplexer_if.slave).
// Each side has its own 2-entry skid buffer so one stalled consumer
// never blocks the other. Optional per-side word counters are enabled
// by defining ONE_BIT_DEMUX_STATS_EN.
module one_bit_demultiplexer
    import core_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    one_bit_demultiplexer_if.slave bus
);
    logic up_full;
    logic down_full;
    logic accept;
    logic push_up;
    logic push_down;

    // in_ready looks only at the selected buffer, never at valid/ready
    assign bus.in_ready = (bus.control == SEL_DOWN) ? !down_full : !up_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push_up      = accept && (bus.control == SEL_UP);
    assign push_down    = accept && (bus.control == SEL_DOWN);

    demux_skid_buffer #(.WIDTH(WIDTH)) u_up (
        .clk       (clk),
        .rst       (rst),
        .push      (push_up),
        .push_data (bus.in_data),
        .pop_ready (bus.up_ready),
        .full      (up_full),
        .valid     (bus.up_valid),
        .head      (bus.out_up)
    );

    demux_skid_buffer #(.WIDTH(WIDTH)) u_down (
        .clk       (clk),
        .rst       (rst),
        .push      (push_down),
        .push_data (bus.in_data),
        .pop_ready (bus.down_ready),
        .full      (down_full),
        .valid     (bus.down_valid),
        .head      (bus.out_down)
    );

`ifdef ONE_BIT_DEMUX_STATS_EN
    logic [15:0] up_count_q, up_count_d;
    logic [15:0] down_count_q, down_count_d;

    always_comb begin
        up_count_d   = up_count_q;
        down_count_d = down_count_q;
        if (push_up)   up_count_d   = up_count_q + 16'd1;
        if (push_down) down_count_d = down_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_count_q   <= '0;
            down_count_q <= '0;
        end else begin
            up_count_q   <= up_count_d;
            down_count_q <= down_count_d;
        end
    end

    assign bus.up_count   = up_count_q;
    assign bus.down_count = down_count_q;
`endif
endmodule

// File: tb/tb_one_bit_demultiplexer.sv
// Directed self-checking bench for one_bit_demultiplexer.
// Define ONE_BIT_DEMUX_STATS_EN to also exercise the word counters.
module tb_one_bit_demultiplexer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    one_bit_demultiplexer_if #(.WIDTH(32)) bus ();

    one_bit_demultiplexer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.in_data    = '0;
        bus.control    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.up_ready   = 1'b0;
        bus.down_ready = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (bus.up_valid !== 1'b0 || bus.down_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got up=%b down=%b want 0 0",
                     bus.up_valid, bus.down_valid);
        end
        total++;
        if (bus.out_up !== 32'h0 || bus.out_down !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got up=%h down=%h want 0 0",
                     bus.out_up, bus.out_down);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready_up: got %b want 1", bus.in_ready);
        end
        bus.control = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready_down: got %b want 1", bus.in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_single_up;
        bus.up_ready = 1'b1;
        bus.control  = 1'b0;
        bus.in_data  = 32'hDEADBEEF;
        bus.in_valid = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_in_ready: got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.up_valid !== 1'b1 || bus.out_up !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_up_out: got v=%b d=%h want 1 deadbeef",
                     bus.up_valid, bus.out_up);
        end
        total++;
        if (bus.down_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_down_quiet: got %b want 0", bus.down_valid);
        end
        tick();
        total++;
        if (bus.up_valid !== 1'b0 || bus.down_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drained: got up=%b down=%b want 0 0",
                     bus.up_valid, bus.down_valid);
        end
        idle_inputs();
    endtask

    task automatic test_stall_down;
        bus.down_ready = 1'b0;
        bus.control    = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 32'h1;
        tick();
        bus.in_data = 32'h2;
        tick();
        bus.in_data = 32'h3;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_full_ready: got %b want 0", bus.in_ready);
        end
        total++;
        if (bus.down_valid !== 1'b1 || bus.out_down !== 32'h1) begin
            bad++;
            $display("FAIL stall_head: got v=%b d=%h want 1 1",
                     bus.down_valid, bus.out_down);
        end
        tick();
        total++;
        if (bus.out_down !== 32'h1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: got d=%h rdy=%b want 1 0",
                     bus.out_down, bus.in_ready);
        end
        bus.down_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_pop_same_cycle: got %b want 0", bus.in_ready);
        end
        tick();
        total++;
        if (bus.out_down !== 32'h2 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_second: got d=%h rdy=%b want 2 1",
                     bus.out_down, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.down_valid !== 1'b1 || bus.out_down !== 32'h3) begin
            bad++;
            $display("FAIL stall_third: got v=%b d=%h want 1 3",
                     bus.down_valid, bus.out_down);
        end
        tick();
        total++;
        if (bus.down_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_drained: got %b want 0", bus.down_valid);
        end
        idle_inputs();
    endtask

    task automatic test_cross_side;
        bus.down_ready = 1'b0;
        bus.up_ready   = 1'b0;
        bus.control    = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 32'h4;
        tick();
        bus.in_data = 32'h5;
        tick();
        bus.control = 1'b0;
        bus.in_data = 32'hA;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL cross_in_ready: got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.up_valid !== 1'b1 || bus.out_up !== 32'hA) begin
            bad++;
            $display("FAIL cross_up_out: got v=%b d=%h want 1 a",
                     bus.up_valid, bus.out_up);
        end
        total++;
        if (bus.down_valid !== 1'b1 || bus.out_down !== 32'h4) begin
            bad++;
            $display("FAIL cross_down_held: got v=%b d=%h want 1 4",
                     bus.down_valid, bus.out_down);
        end
        bus.up_ready   = 1'b1;
        bus.down_ready = 1'b1;
        tick();
        total++;
        if (bus.up_valid !== 1'b0 || bus.out_down !== 32'h5) begin
            bad++;
            $display("FAIL cross_drain: got upv=%b d=%h want 0 5",
                     bus.up_valid, bus.out_down);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        logic [31:0] w;
        logic        sel;
        bus.up_ready   = 1'b1;
        bus.down_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w   = 32'h10 + 32'(i);
            sel = (i % 2) == 1;
            bus.in_data  = w;
            bus.control  = sel;
            bus.in_valid = 1'b1;
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            tick();
            total++;
            if (!sel && (bus.up_valid !== 1'b1 || bus.out_up !== w ||
                         bus.down_valid !== 1'b0)) begin
                bad++;
                $display("FAIL b2b_up[%0d]: got v=%b d=%h dv=%b want 1 %h 0",
                         i, bus.up_valid, bus.out_up, bus.down_valid, w);
            end else if (sel && (bus.down_valid !== 1'b1 ||
                                 bus.out_down !== w ||
                                 bus.up_valid !== 1'b0)) begin
                bad++;
                $display("FAIL b2b_down[%0d]: got v=%b d=%h uv=%b want 1 %h 0",
                         i, bus.down_valid, bus.out_down, bus.up_valid, w);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        total++;
        if (bus.up_valid !== 1'b0 || bus.down_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drained: got up=%b down=%b want 0 0",
                     bus.up_valid, bus.down_valid);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        bus.up_ready = 1'b0;
        bus.control  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        tick();
        bus.in_data = 32'h78;
        tick();
        total++;
        if (bus.up_valid !== 1'b1 || bus.out_up !== 32'h77) begin
            bad++;
            $display("FAIL rstmid_pre: got v=%b d=%h want 1 77",
                     bus.up_valid, bus.out_up);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (bus.up_valid !== 1'b0 || bus.down_valid !== 1'b0 ||
            bus.out_up !== 32'h0 || bus.out_down !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_async: got uv=%b dv=%b u=%h d=%h want 0",
                     bus.up_valid, bus.down_valid, bus.out_up, bus.out_down);
        end
        bus.in_valid = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (bus.in_ready !== 1'b1 || bus.up_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_after: got rdy=%b uv=%b want 1 0",
                     bus.in_ready, bus.up_valid);
        end
        bus.up_ready = 1'b1;
        tick();
        total++;
        if (bus.up_valid !== 1'b0 || bus.out_up !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_no_old: got v=%b d=%h want 0 0",
                     bus.up_valid, bus.out_up);
        end
        idle_inputs();
    endtask

`ifdef ONE_BIT_DEMUX_STATS_EN
    task automatic test_stats;
        idle_inputs();
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus.up_ready = 1'b1;
        bus.control  = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.in_data = 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        total++;
        if (bus.up_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL stats_preload: got %h want ffff", bus.up_count);
        end
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.up_count !== 16'h0000 || bus.down_count !== 16'h0000) begin
            bad++;
            $display("FAIL stats_wrap: got up=%h down=%h want 0000 0000",
                     bus.up_count, bus.down_count);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_single_up();
        test_stall_down();
        test_cross_side();
        test_back_to_back();
        test_reset_mid();
`ifdef ONE_BIT_DEMUX_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
